// File: rtl/fft_r22sdf_reorder_if.sv
// Stream bundle for the FFT output reorder buffer: bit-reversed input side
// from the FFT core and natural-order output side toward spectral processing.
interface fft_r22sdf_reorder_if #(
    parameter int N_LOG2     = 10,
    parameter int DATA_WIDTH = 25
);
    logic                         sync_i;
    logic [N_LOG2-1:0]            ctr_i;
    logic signed [DATA_WIDTH-1:0] data_re_i;
    logic signed [DATA_WIDTH-1:0] data_im_i;

    logic                         valid_o;
    logic [N_LOG2-1:0]            ctr_o;
    logic                         last_o;
    logic signed [DATA_WIDTH-1:0] data_re_o;
    logic signed [DATA_WIDTH-1:0] data_im_o;
    logic                         frame_drop_o;

    modport master (
        output sync_i, ctr_i, data_re_i, data_im_i,
        input  valid_o, ctr_o, last_o, data_re_o, data_im_o,
        input  frame_drop_o
    );

    modport slave (
        input  sync_i, ctr_i, data_re_i, data_im_i,
        output valid_o, ctr_o, last_o, data_re_o, data_im_o,
        output frame_drop_o
    );
endinterface

// File: rtl/fft_r22sdf_reorder.sv
// Ping-pong reorder buffer: bit-reversed FFT frames out in natural bin order.
// FFT_REORDER_FFTSHIFT_EN: read order N/2..N-1, 0..N/2-1 (DC centred).
module fft_r22sdf_reorder #(
    parameter int N          = 1024,
    parameter int N_LOG2     = 10,
    parameter int DATA_WIDTH = 25
) (
    input  logic               clk_i,
    input  logic               rst_n,
    fft_r22sdf_reorder_if.slave bus
);
    localparam int AW = N_LOG2 + 1;
    localparam int WW = 2 * DATA_WIDTH;
    localparam logic [N_LOG2-1:0] CNT_MAX = N_LOG2'(N - 1);

    typedef enum logic { W_IDLE, W_FILL } w_state_e;
    typedef enum logic { R_IDLE, R_READ } r_state_e;

    w_state_e           w_state_q, w_state_d;
    logic [N_LOG2-1:0]  wcnt_q, wcnt_d;
    logic               wr_bank_q, wr_bank_d;
    logic               frame_done_q, frame_done_d;
    logic               drop_q, drop_d;

    r_state_e           r_state_q, r_state_d;
    logic [N_LOG2-1:0]  rcnt_q, rcnt_d;
    logic               rd_bank_q, rd_bank_d;

    logic               s1_valid_q, s1_valid_d;
    logic [N_LOG2-1:0]  s1_ctr_q, s1_ctr_d;
    logic               s1_last_q, s1_last_d;

    logic               valid_q, valid_d;
    logic [N_LOG2-1:0]  ctr_q, ctr_d;
    logic               last_q, last_d;
    logic [DATA_WIDTH-1:0] re_q, re_d;
    logic [DATA_WIDTH-1:0] im_q, im_d;

    logic               we;
    logic [AW-1:0]      waddr;
    logic [WW-1:0]      wdata;
    logic               rd_en;
    logic [N_LOG2-1:0]  raddr_lo;
    logic [AW-1:0]      raddr;
    logic               rcnt_end;

    logic [WW-1:0]      mem_q [2*N];
    logic [WW-1:0]      rd_data_q;

    always_comb begin
        w_state_d    = w_state_q;
        wcnt_d       = wcnt_q;
        wr_bank_d    = wr_bank_q;
        frame_done_d = 1'b0;
        drop_d       = 1'b0;
        we           = bus.sync_i;
        waddr        = {wr_bank_q, bus.ctr_i};
        wdata        = {bus.data_re_i, bus.data_im_i};
        unique case (1'b1)
            bus.sync_i && (wcnt_q == CNT_MAX): begin
                w_state_d    = W_FILL;
                wcnt_d       = '0;
                wr_bank_d    = ~wr_bank_q;
                frame_done_d = 1'b1;
            end
            bus.sync_i && (wcnt_q != CNT_MAX): begin
                w_state_d = W_FILL;
                wcnt_d    = wcnt_q + N_LOG2'(1);
            end
            !bus.sync_i: begin
                // A lone completed frame leaves wcnt at 0, so no drop then.
                drop_d    = (w_state_q == W_FILL) && (wcnt_q != '0);
                w_state_d = W_IDLE;
                wcnt_d    = '0;
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_en    = (r_state_q == R_READ);
        rcnt_end = (rcnt_q == CNT_MAX);
`ifdef FFT_REORDER_FFTSHIFT_EN
        raddr_lo = {~rcnt_q[N_LOG2-1], rcnt_q[N_LOG2-2:0]};
`else
        raddr_lo = rcnt_q;
`endif
        raddr     = {rd_bank_q, raddr_lo};
        r_state_d = r_state_q;
        rcnt_d    = rcnt_q;
        rd_bank_d = rd_bank_q;
        unique case (1'b1)
            frame_done_q: begin
                // wr_bank has already toggled, so the filled bank is its inverse.
                r_state_d = R_READ;
                rcnt_d    = '0;
                rd_bank_d = ~wr_bank_q;
            end
            !frame_done_q && rd_en && rcnt_end: begin
                r_state_d = R_IDLE;
                rcnt_d    = '0;
            end
            !frame_done_q && rd_en && !rcnt_end: begin
                rcnt_d = rcnt_q + N_LOG2'(1);
            end
            !frame_done_q && !rd_en: ;
            default: ;
        endcase
    end

    always_comb begin
        s1_valid_d = rd_en;
        s1_ctr_d   = rd_en ? raddr_lo : '0;
        s1_last_d  = rd_en && rcnt_end;
        valid_d    = s1_valid_q;
        ctr_d      = s1_ctr_q;
        last_d     = s1_last_q;
        re_d       = s1_valid_q ? rd_data_q[WW-1:DATA_WIDTH] : '0;
        im_d       = s1_valid_q ? rd_data_q[DATA_WIDTH-1:0] : '0;
    end

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[raddr];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            w_state_q    <= W_IDLE;
            wcnt_q       <= '0;
            wr_bank_q    <= 1'b0;
            frame_done_q <= 1'b0;
            drop_q       <= 1'b0;
            r_state_q    <= R_IDLE;
            rcnt_q       <= '0;
            rd_bank_q    <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_ctr_q     <= '0;
            s1_last_q    <= 1'b0;
            valid_q      <= 1'b0;
            ctr_q        <= '0;
            last_q       <= 1'b0;
            re_q         <= '0;
            im_q         <= '0;
        end else begin
            w_state_q    <= w_state_d;
            wcnt_q       <= wcnt_d;
            wr_bank_q    <= wr_bank_d;
            frame_done_q <= frame_done_d;
            drop_q       <= drop_d;
            r_state_q    <= r_state_d;
            rcnt_q       <= rcnt_d;
            rd_bank_q    <= rd_bank_d;
            s1_valid_q   <= s1_valid_d;
            s1_ctr_q     <= s1_ctr_d;
            s1_last_q    <= s1_last_d;
            valid_q      <= valid_d;
            ctr_q        <= ctr_d;
            last_q       <= last_d;
            re_q         <= re_d;
            im_q         <= im_d;
        end
    end

    assign bus.valid_o      = valid_q;
    assign bus.ctr_o        = ctr_q;
    assign bus.last_o       = last_q;
    assign bus.data_re_o    = re_q;
    assign bus.data_im_o    = im_q;
    assign bus.frame_drop_o = drop_q;
endmodule

// File: tb/tb_fft_r22sdf_reorder.sv
// Directed bench for the reorder buffer at N=16: frame table driven in
// bit-reversed order, captured output compared against natural-order model.
module tb_fft_r22sdf_reorder;
    localparam int N  = 16;
    localparam int NL = 4;
    localparam int DW = 25;
`ifdef FFT_REORDER_FFTSHIFT_EN
    localparam bit SHIFT = 1'b1;
`else
    localparam bit SHIFT = 1'b0;
`endif

    typedef struct {
        string name;
        int    re_off;
        int    re_step;
        int    im_step;
        bit    spike_en;
        int    spike_bin;
        int    spike_re;
        int    spike_im;
    } frame_t;

    typedef struct {
        int cyc;
        int ctr;
        int re;
        int im;
        bit last;
    } cap_t;

    logic clk_i = 1'b0;
    logic rst_n = 1'b0;

    fft_r22sdf_reorder_if #(.N_LOG2(NL), .DATA_WIDTH(DW)) bus ();

    fft_r22sdf_reorder #(.N(N), .N_LOG2(NL), .DATA_WIDTH(DW)) dut (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    int     tests = 0;
    int     fails = 0;
    int     cyc = 0;
    int     drop_cnt = 0;
    int     last_edge = 0;
    cap_t   cap_q[$];
    frame_t tbl[8];

    always @(posedge clk_i) begin
        #1;
        cyc++;
        if (bus.valid_o === 1'b1) begin
            cap_q.push_back('{cyc, int'(bus.ctr_o), int'(bus.data_re_o),
                              int'(bus.data_im_o), bus.last_o});
        end
        if (bus.frame_drop_o === 1'b1) drop_cnt++;
    end

    function automatic void check(input string nm, input int act,
                                  input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endfunction

    function automatic int bitrev(input int k);
        int r = 0;
        for (int i = 0; i < NL; i++) r |= ((k >> i) & 1) << (NL - 1 - i);
        return r;
    endfunction

    function automatic int f_re(input frame_t f, input int b);
        if (f.spike_en) return (b == f.spike_bin) ? f.spike_re : 0;
        return f.re_off + f.re_step * b;
    endfunction

    function automatic int f_im(input frame_t f, input int b);
        if (f.spike_en) return (b == f.spike_bin) ? f.spike_im : 0;
        return f.im_step * b;
    endfunction

    function automatic int bin_at(input int k);
        return SHIFT ? (k ^ (N / 2)) : k;
    endfunction

    task automatic drive_frame(input frame_t f, input int nsamp);
        int b;
        for (int k = 0; k < nsamp; k++) begin
            @(negedge clk_i);
            b = bitrev(k);
            bus.sync_i    = 1'b1;
            bus.ctr_i     = b[NL-1:0];
            bus.data_re_i = DW'(f_re(f, b));
            bus.data_im_i = DW'(f_im(f, b));
        end
        last_edge = cyc + 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            bus.sync_i    = 1'b0;
            bus.ctr_i     = '0;
            bus.data_re_i = '0;
            bus.data_im_i = '0;
        end
    endtask

    task automatic wait_caps(input int n, input string nm);
        int c = 0;
        while (cap_q.size() < n && c < 200) begin
            @(posedge clk_i);
            #2;
            c++;
        end
        if (cap_q.size() < n) begin
            check({nm, "_timeout"}, cap_q.size(), n);
        end
    endtask

    task automatic check_frame(input frame_t f, input int base,
                               input int start_cyc);
        int e;
        string nm;
        for (int i = 0; i < N; i++) begin
            nm = $sformatf("%s[%0d]", f.name, i);
            if (base + i >= cap_q.size()) begin
                check({nm, "_missing"}, cap_q.size(), base + i + 1);
            end else begin
                e = bin_at(i);
                check({nm, ".ctr"}, cap_q[base+i].ctr, e);
                check({nm, ".re"}, cap_q[base+i].re, f_re(f, e));
                check({nm, ".im"}, cap_q[base+i].im, f_im(f, e));
                check({nm, ".last"}, int'(cap_q[base+i].last), int'(i == N-1));
                check({nm, ".cyc"}, cap_q[base+i].cyc, start_cyc + i);
            end
        end
    endtask

    task automatic check_idle_outputs(input string nm);
        check({nm, ".valid"}, int'(bus.valid_o), 0);
        check({nm, ".ctr"}, int'(bus.ctr_o), 0);
        check({nm, ".last"}, int'(bus.last_o), 0);
        check({nm, ".re"}, int'(bus.data_re_o), 0);
        check({nm, ".im"}, int'(bus.data_im_o), 0);
        check({nm, ".drop"}, int'(bus.frame_drop_o), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int le1;
        int nlast;
        int drop0;

        tbl[0] = '{"single",   100, 1, -1, 1'b0, 0, 0, 0};
        tbl[1] = '{"cont1",   1000, 1,  1, 1'b0, 0, 0, 0};
        tbl[2] = '{"cont2",   2000, 1,  2, 1'b0, 0, 0, 0};
        tbl[3] = '{"cont3",   3000, 1,  3, 1'b0, 0, 0, 0};
        tbl[4] = '{"afterdrop",  0, 1,  3, 1'b0, 0, 0, 0};
        tbl[5] = '{"fullscale",  0, 0,  0, 1'b1, 5, -16777216, 16777215};
        tbl[6] = '{"prerst",   200, 1, -2, 1'b0, 0, 0, 0};
        tbl[7] = '{"postrst",  300, 1,  5, 1'b0, 0, 0, 0};

        bus.sync_i    = 1'b0;
        bus.ctr_i     = '0;
        bus.data_re_i = '0;
        bus.data_im_i = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk_i);
        #2;
        check_idle_outputs("reset");
        @(negedge clk_i);
        rst_n = 1'b1;
        idle(2);

        cap_q.delete();
        drive_frame(tbl[0], N);
        idle(1);
        wait_caps(N, "single");
        idle(4);
        check("single_count", cap_q.size(), N);
        check_frame(tbl[0], 0, last_edge + 3);
        check("single_drop", drop_cnt, 0);

        cap_q.delete();
        drive_frame(tbl[1], N);
        le1 = last_edge;
        drive_frame(tbl[2], N);
        drive_frame(tbl[3], N);
        idle(1);
        wait_caps(3 * N, "cont");
        idle(4);
        check("cont_count", cap_q.size(), 3 * N);
        check_frame(tbl[1], 0, le1 + 3);
        check_frame(tbl[2], N, le1 + 3 + N);
        check_frame(tbl[3], 2 * N, le1 + 3 + 2 * N);
        nlast = 0;
        foreach (cap_q[i]) if (cap_q[i].last) nlast++;
        check("cont_last_pulses", nlast, 3);
        check("cont_drop", drop_cnt, 0);

        cap_q.delete();
        drop0 = drop_cnt;
        drive_frame(tbl[0], 7);
        idle(4);
        check("drop_pulse", drop_cnt - drop0, 1);
        check("drop_no_output", cap_q.size(), 0);
        drive_frame(tbl[4], N);
        idle(1);
        wait_caps(N, "afterdrop");
        idle(6);
        check("afterdrop_count", cap_q.size(), N);
        check_frame(tbl[4], 0, last_edge + 3);
        check("afterdrop_drop", drop_cnt - drop0, 1);

        cap_q.delete();
        drive_frame(tbl[5], N);
        idle(1);
        wait_caps(N, "fullscale");
        idle(4);
        check("fullscale_count", cap_q.size(), N);
        check_frame(tbl[5], 0, last_edge + 3);

        cap_q.delete();
        drop0 = drop_cnt;
        drive_frame(tbl[6], N);
        idle(1);
        wait_caps(5, "prerst");
        @(negedge clk_i);
        rst_n = 1'b0;
        @(posedge clk_i);
        #2;
        check_idle_outputs("midrst");
        check("midrst_caps", cap_q.size(), 5);
        idle(2);
        rst_n = 1'b1;
        idle(10);
        check("postrst_no_residue", cap_q.size(), 5);
        check("postrst_drop", drop_cnt - drop0, 0);
        cap_q.delete();
        drive_frame(tbl[7], N);
        idle(1);
        wait_caps(N, "postrst");
        idle(4);
        check("postrst_count", cap_q.size(), N);
        check_frame(tbl[7], 0, last_edge + 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fft_r22sdf_reorder.md
Name: fft_r22sdf_reorder

Overview:
Output-side consumer of the radix-2^2 SDF FFT stream. It accepts the FFT's bit-reversed-order output (sync, natural bin index, re/im) and re-emits each complete frame in natural bin order. It uses a ping-pong buffer of two N-entry banks, so continuous back-to-back frames stream through at one sample per clk_i with no stall. It sits between the FFT output registers and downstream spectral processing (windowed magnitude, peak search, host readout).

Parameters:
N, 1024, FFT length; power of 2, >= 4
N_LOG2, 10, log2(N)
DATA_WIDTH, 25, width of each re/im sample; equals the FFT OUTPUT_WIDTH

Ports:
clk_i  input  1  system clock, same domain as the FFT clk_i
rst_n  input  1  reset, synchronous, active-low
sync_i  input  1  input sample valid; connects to FFT sync_o, high continuously while frames stream
ctr_i  input  N_LOG2  natural-order bin index of the current input sample; connects to FFT data_ctr_o
data_re_i  input  DATA_WIDTH  signed real part
data_im_i  input  DATA_WIDTH  signed imaginary part
valid_o  output  1  output sample valid
ctr_o  output  N_LOG2  natural-order bin index of the output sample
last_o  output  1  high with the final sample of an output frame
data_re_o  output  DATA_WIDTH  signed real part, natural order
data_im_o  output  DATA_WIDTH  signed imaginary part, natural order
frame_drop_o  output  1  one-cycle pulse when a partial input frame is discarded

Behaviour:
- Storage: 2 banks x N words x 2*DATA_WIDTH bits, held in inferred block RAM. RAM contents are not reset.
- Sign: data passes through bit-exact with no width change, rounding or saturation.
- Write side FSM:
  - States: W_IDLE, W_FILL. Counter wcnt has N_LOG2 bits. wr_bank is 1 bit.
  - Any cycle with sync_i=1 writes {re,im} to wr_bank[ctr_i] and increments wcnt.
  - W_IDLE -> W_FILL on the first sample with sync_i=1.
  - When wcnt==N-1 and sync_i=1, the frame is complete:
    - wcnt wraps to 0 and wr_bank toggles.
    - A one-cycle frame_done strobe is generated.
    - The FSM stays in W_FILL if sync_i remains high.
  - If sync_i falls while wcnt!=0:
    - The partial frame is discarded and wcnt is set to 0.
    - wr_bank is not toggled, and the FSM goes to W_IDLE.
    - frame_drop_o pulses for 1 cycle on the following cycle.
  - ctr_i is trusted. Duplicate indices within a frame overwrite, and unwritten addresses read back stale data.
- Read side FSM:
  - States: R_IDLE, R_READ. Counter rcnt has N_LOG2 bits. rd_bank is 1 bit.
  - On frame_done: rd_bank <= the bank just filled, rcnt <= 0, state -> R_READ.
  - In R_READ, the block issues a read of rd_bank[raddr] each cycle with raddr=rcnt, and rcnt increments.
  - At rcnt==N-1, it returns to R_IDLE unless frame_done coincides; in that case it restarts at rcnt=0 on the new bank with no gap.
- Output pipeline: RAM has 1-cycle registered read, plus 1 output register stage.
  - valid_o, ctr_o, last_o and data are aligned.
  - ctr_o equals the raddr delayed by 2 cycles.
  - last_o is asserted when the delayed rcnt==N-1.
- Latency: the last input sample of a frame is sampled at edge t. frame_done is registered at edge t+1, which drives the first read address. The output of bin 0 becomes valid at edge t+3, and bin k at edge t+3+k.
- Throughput: one frame per N cycles sustained. Since read and write both take N cycles per frame, a bank is never written while being read.
- Reset:
  - Reset values: valid_o=0, last_o=0, frame_drop_o=0, ctr_o=0, data_re_o=0, data_im_o=0.
  - Internal reset values: both FSMs idle, wcnt=rcnt=0, wr_bank=0.
  - Reset asserted mid-operation aborts any readout and any partial write immediately. valid_o is 0 from the first edge with rst_n=0, and no frame_drop_o is generated.
- Simultaneous events:
  - frame_done arriving on the same cycle as the final read of the previous frame produces seamless back-to-back output.
  - A sync_i fall on the same cycle as completion of a full frame counts as complete, not dropped.

Optional Feature:
FFT_REORDER_FFTSHIFT_EN
- Defined: the read address is rcnt with its MSB inverted, so the output order is bins N/2..N-1 followed by 0..N/2-1 (zero frequency centred). ctr_o reports the actual bin read.
- Undefined: bins are read in the order 0..N-1.
- Latency, last_o timing and all other behaviour are identical with and without the macro.

Test Plan:
All scenarios use N=16, N_LOG2=4, DATA_WIDTH=25.
1. Single frame: sync_i high for 16 cycles, ctr_i=bitrev4(k), data_re_i=100+bitrev4(k), data_im_i=-bitrev4(k) -> valid_o high for 16 cycles starting 3 edges after the last input. ctr_o runs 0..15, data_re_o runs 100..115, data_im_o runs 0..-15, and last_o is high only with ctr_o=15.
2. Three continuous frames where frame f uses data_re_i=1000*f+bin -> 48 contiguous valid_o cycles with no gap. Each frame is in ascending bin order with correct f, and last_o pulses 3 times.
3. sync_i high for 7 samples, low for 4 cycles, then a full frame with data_re_i=bin -> frame_drop_o pulses once, exactly one 16-sample output frame appears, and data_re_o runs 0..15.
4. Full-scale signed values: data_re_i=-2^24 and data_im_i=2^24-1 at bin 5, zero elsewhere -> bin 5 outputs -16777216 and 16777215 exactly, and all other bins output 0.
5. Reset at the 6th output sample of a frame -> valid_o=0 and all outputs 0 from the first edge with rst_n=0. After release, a new full frame outputs correctly with no residue of the aborted frame.
6. With FFT_REORDER_FFTSHIFT_EN, scenario 1 -> ctr_o runs 8..15 then 0..7, data_re_o=100+ctr_o, and last_o is high on the 16th output (ctr_o=7).
